// File: rtl/param_datapath.sv
// Bus-based CPU datapath: register file, HI/LO/Y/Z/PC/MAR/MDR, shared bus and sequenced ALU.
// Define PARAM_DATAPATH_MULDIV_EN to build the iterative MUL/DIV sequencer.
module param_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int RSW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             reg_wr,
    input  logic [RSW-1:0]   reg_wsel,
    input  logic             reg_rd,
    input  logic [RSW-1:0]   reg_rsel,
    input  logic             ba_out,
    input  logic [2:0]       src_sel,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] inport_data,
    input  logic             hi_in,
    input  logic             lo_in,
    input  logic             y_in,
    input  logic             mar_in,
    input  logic             pc_in,
    input  logic             pc_inc,
    input  logic             mdr_in,
    input  logic             mdr_rd,
    input  logic [WIDTH-1:0] mem_data_in,
    input  logic [4:0]       opcode,
    input  logic             alu_start,
    output logic             alu_busy,
    output logic             alu_done,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] mar_q,
    output logic [WIDTH-1:0] mdr_q,
    output logic [WIDTH-1:0] pc_q
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]   regFile_q [NREGS];
    logic [WIDTH-1:0]   hi_q, lo_q, y_q;
    logic [2*WIDTH-1:0] z_q, zNext;
    logic               zWrite, done_q;
    logic [WIDTH-1:0]   singleRes;
    logic [SHW-1:0]     shAmt;
    logic [2*WIDTH-1:0] rotR, rotL;

    // R0 only reads as zero when used as a base address (ba_out).
    always_comb begin
        bus = '0;
        if (reg_rd) begin
            if (!(ba_out && reg_rsel == '0)) bus = regFile_q[reg_rsel];
        end else begin
            case (src_sel)
                3'd0: bus = hi_q;
                3'd1: bus = lo_q;
                3'd2: bus = z_q[2*WIDTH-1:WIDTH];
                3'd3: bus = z_q[WIDTH-1:0];
                3'd4: bus = pc_q;
                3'd5: bus = mdr_q;
                3'd6: bus = inport_data;
                3'd7: bus = imm;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) regFile_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            y_q   <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            pc_q  <= '0;
        end else begin
            if (reg_wr) regFile_q[reg_wsel] <= bus;
            if (hi_in)  hi_q  <= bus;
            if (lo_in)  lo_q  <= bus;
            if (y_in)   y_q   <= bus;
            if (mar_in) mar_q <= bus;
            if (pc_in)       pc_q <= bus;
            else if (pc_inc) pc_q <= pc_q + WIDTH'(1);
            if (mdr_in) mdr_q <= mdr_rd ? mem_data_in : bus;
        end
    end

    assign shAmt = bus[SHW-1:0];

    // Rotates are taken from a doubled copy of A so a zero amount needs no special case.
    always_comb begin
        rotR      = {y_q, y_q} >> shAmt;
        rotL      = {y_q, y_q} << shAmt;
        singleRes = '0;
        case (opcode)
            5'd0:    singleRes = y_q + bus;
            5'd1:    singleRes = y_q - bus;
            5'd2:    singleRes = y_q & bus;
            5'd3:    singleRes = y_q | bus;
            5'd4:    singleRes = y_q >> shAmt;
            5'd5:    singleRes = $signed(y_q) >>> shAmt;
            5'd6:    singleRes = y_q << shAmt;
            5'd7:    singleRes = rotR[WIDTH-1:0];
            5'd8:    singleRes = rotL[2*WIDTH-1:WIDTH];
            5'd9:    singleRes = -bus;
            5'd10:   singleRes = ~bus;
            default: singleRes = '0;
        endcase
    end

`ifdef PARAM_DATAPATH_MULDIV_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX} aluState_e;

    aluState_e          state_q, state_d;
    logic [SHW-1:0]     cnt_q;
    logic               isMul_q, negQ_q, negR_q, divZero_q;
    logic [WIDTH-1:0]   dividend_q, mplier_q, quot_q, divisor_q, rem_q;
    logic [2*WIDTH-1:0] mcand_q, prod_q, fixRes;
    logic               isIter, startIter;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [WIDTH:0]     remShift, remTrial;

    assign isIter    = (opcode == 5'd11) || (opcode == 5'd12);
    assign startIter = (state_q == IDLE) && alu_start && isIter;
    assign aMag      = y_q[WIDTH-1] ? -y_q : y_q;
    assign bMag      = bus[WIDTH-1] ? -bus : bus;
    assign remShift  = {rem_q, quot_q[WIDTH-1]};
    assign remTrial  = remShift - {1'b0, divisor_q};

    always_ff @(posedge clk) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startIter) state_d = RUN;
            RUN:     if (cnt_q == SHW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_busy = (state_q != IDLE);
        zWrite   = 1'b0;
        zNext    = {{WIDTH{1'b0}}, singleRes};
        if (state_q == FIX) begin
            zWrite = 1'b1;
            zNext  = fixRes;
        end else if (state_q == IDLE && alu_start && !isIter) begin
            zWrite = 1'b1;
        end
    end

    // Iterations run on magnitudes; signs are applied once in FIX.
    always_comb begin
        if (isMul_q) begin
            fixRes = negQ_q ? -prod_q : prod_q;
        end else if (divZero_q) begin
            fixRes = {dividend_q, {WIDTH{1'b1}}};
        end else begin
            fixRes[WIDTH-1:0]       = negQ_q ? -quot_q : quot_q;
            fixRes[2*WIDTH-1:WIDTH] = negR_q ? -rem_q : rem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q      <= '0;
            isMul_q    <= 1'b0;
            negQ_q     <= 1'b0;
            negR_q     <= 1'b0;
            divZero_q  <= 1'b0;
            dividend_q <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
        end else if (startIter) begin
            cnt_q      <= '0;
            isMul_q    <= (opcode == 5'd11);
            negQ_q     <= y_q[WIDTH-1] ^ bus[WIDTH-1];
            negR_q     <= y_q[WIDTH-1];
            divZero_q  <= (bus == '0);
            dividend_q <= y_q;
            mcand_q    <= {{WIDTH{1'b0}}, aMag};
            mplier_q   <= bMag;
            prod_q     <= '0;
            quot_q     <= aMag;
            divisor_q  <= bMag;
            rem_q      <= '0;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + SHW'(1);
            if (isMul_q) begin
                if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end else if (!remTrial[WIDTH]) begin
                rem_q  <= remTrial[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q  <= remShift[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    always_comb begin
        alu_busy = 1'b0;
        zWrite   = alu_start;
        zNext    = {{WIDTH{1'b0}}, singleRes};
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            z_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= zWrite;
            if (zWrite) z_q <= zNext;
        end
    end

    assign alu_done = done_q;

endmodule

// File: tb/tb_param_datapath.sv
// Directed testbench for param_datapath: ALU vector table plus hand-written register,
// bus and multi-cycle sequences (MUL/DIV checks follow PARAM_DATAPATH_MULDIV_EN).
module tb_param_datapath;
    localparam int WIDTH = 32;
    localparam int NREGS = 16;
    localparam int RSW   = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic             reg_wr, reg_rd, ba_out;
    logic [RSW-1:0]   reg_wsel, reg_rsel;
    logic [2:0]       src_sel;
    logic [WIDTH-1:0] imm, inport_data, mem_data_in;
    logic             hi_in, lo_in, y_in, mar_in, pc_in, pc_inc, mdr_in, mdr_rd;
    logic [4:0]       opcode;
    logic             alu_start, alu_busy, alu_done;
    logic [WIDTH-1:0] bus, mar_q, mdr_q, pc_q;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
    } vec_t;

    vec_t vecs[$];

    param_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk(clk), .clr(clr),
        .reg_wr(reg_wr), .reg_wsel(reg_wsel), .reg_rd(reg_rd), .reg_rsel(reg_rsel),
        .ba_out(ba_out), .src_sel(src_sel), .imm(imm), .inport_data(inport_data),
        .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in), .mar_in(mar_in),
        .pc_in(pc_in), .pc_inc(pc_inc), .mdr_in(mdr_in), .mdr_rd(mdr_rd),
        .mem_data_in(mem_data_in), .opcode(opcode), .alu_start(alu_start),
        .alu_busy(alu_busy), .alu_done(alu_done), .bus(bus),
        .mar_q(mar_q), .mdr_q(mdr_q), .pc_q(pc_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleInputs();
        clr = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; ba_out = 1'b0;
        reg_wsel = '0; reg_rsel = '0; src_sel = 3'd0; imm = '0;
        inport_data = '0; mem_data_in = '0;
        hi_in = 1'b0; lo_in = 1'b0; y_in = 1'b0; mar_in = 1'b0;
        pc_in = 1'b0; pc_inc = 1'b0; mdr_in = 1'b0; mdr_rd = 1'b0;
        opcode = '0; alu_start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic addVec(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] z);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.z = z;
        vecs.push_back(v);
    endtask

    task automatic writeReg(input logic [RSW-1:0] idx, input logic [31:0] val);
        reg_wr = 1'b1; reg_wsel = idx; src_sel = 3'd7; imm = val;
        tick();
        idleInputs();
    endtask

    task automatic readReg(input logic [RSW-1:0] idx, input logic ba, output logic [31:0] val);
        reg_rd = 1'b1; reg_rsel = idx; ba_out = ba;
        #1;
        val = bus;
        reg_rd = 1'b0; ba_out = 1'b0;
    endtask

    task automatic loadY(input logic [31:0] val);
        y_in = 1'b1; src_sel = 3'd7; imm = val;
        tick();
        idleInputs();
    endtask

    task automatic readZ(output logic [63:0] z);
        src_sel = 3'd2;
        #1;
        z[63:32] = bus;
        src_sel = 3'd3;
        #1;
        z[31:0] = bus;
        src_sel = 3'd0;
    endtask

    task automatic startOp(input logic [4:0] op, input logic [31:0] b);
        opcode = op; src_sel = 3'd7; imm = b; alu_start = 1'b1;
        tick();
        idleInputs();
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [63:0] z;
        loadY(v.a);
        startOp(v.op, v.b);
        checkOutput({v.name, " done"}, {63'd0, alu_done}, 64'd1);
        readZ(z);
        checkOutput({v.name, " Z"}, z, v.z);
    endtask

    task automatic runIter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] z, output int lat);
        loadY(a);
        startOp(op, b);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (alu_done) begin
                lat = i;
                break;
            end
        end
        readZ(z);
    endtask

    initial begin
        logic [63:0] z;
        logic [31:0] v;
        int          lat;
        int          doneSeen;
        logic        busyMid;

        idleInputs();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;

        checkOutput("reset pc", pc_q, 0);
        checkOutput("reset mar", mar_q, 0);
        checkOutput("reset mdr", mdr_q, 0);
        checkOutput("reset busy", {63'd0, alu_busy}, 0);
        checkOutput("reset done", {63'd0, alu_done}, 0);
        readReg(4'd5, 1'b0, v);
        checkOutput("reset R5", v, 0);
        readZ(z);
        checkOutput("reset Z", z, 0);

        // ADD through the register file: R1=5, R2=7, Y<-R1, B<-R2.
        writeReg(4'd1, 32'd5);
        writeReg(4'd2, 32'd7);
        readReg(4'd1, 1'b0, v);
        checkOutput("R1 write-then-read", v, 5);
        reg_rd = 1'b1; reg_rsel = 4'd1; y_in = 1'b1;
        tick();
        idleInputs();
        reg_rd = 1'b1; reg_rsel = 4'd2; opcode = 5'd0; alu_start = 1'b1;
        tick();
        idleInputs();
        checkOutput("add done", {63'd0, alu_done}, 1);
        readZ(z);
        checkOutput("add Z", z, 64'd12);
        tick();
        checkOutput("add done drops", {63'd0, alu_done}, 0);

        writeReg(4'd0, 32'h55);
        readReg(4'd0, 1'b1, v);
        checkOutput("R0 ba_out=1", v, 0);
        readReg(4'd0, 1'b0, v);
        checkOutput("R0 ba_out=0", v, 32'h55);

        src_sel = 3'd7; imm = 32'h40; pc_in = 1'b1; pc_inc = 1'b1;
        tick();
        idleInputs();
        checkOutput("pc_in wins", pc_q, 32'h40);
        pc_inc = 1'b1;
        tick();
        idleInputs();
        checkOutput("pc_inc", pc_q, 32'h41);
        src_sel = 3'd4;
        #1;
        checkOutput("bus PC", bus, 32'h41);
        idleInputs();

        src_sel = 3'd7; imm = 32'hABC; mar_in = 1'b1;
        tick();
        idleInputs();
        checkOutput("mar load", mar_q, 32'hABC);
        mdr_in = 1'b1; mdr_rd = 1'b1; mem_data_in = 32'hDEAD; src_sel = 3'd7; imm = 32'h77;
        tick();
        idleInputs();
        checkOutput("mdr from mem", mdr_q, 32'hDEAD);
        mdr_in = 1'b1; mem_data_in = 32'hDEAD; src_sel = 3'd7; imm = 32'h77;
        tick();
        idleInputs();
        checkOutput("mdr from bus", mdr_q, 32'h77);
        src_sel = 3'd5;
        #1;
        checkOutput("bus MDR", bus, 32'h77);
        idleInputs();

        src_sel = 3'd7; imm = 32'h1111; hi_in = 1'b1;
        tick();
        idleInputs();
        src_sel = 3'd7; imm = 32'h2222; lo_in = 1'b1;
        tick();
        idleInputs();
        src_sel = 3'd0;
        #1;
        checkOutput("bus HI", bus, 32'h1111);
        src_sel = 3'd1;
        #1;
        checkOutput("bus LO", bus, 32'h2222);
        src_sel = 3'd6; inport_data = 32'hCAFE;
        #1;
        checkOutput("bus InPort", bus, 32'hCAFE);
        idleInputs();

`ifdef PARAM_DATAPATH_MULDIV_EN
        // MUL with an ignored start at +5 and Y/bus changing mid-run.
        loadY(32'hFFFFFFFD);
        startOp(5'd11, 32'h10000);
        checkOutput("mul busy", {63'd0, alu_busy}, 1);
        lat = 0;
        busyMid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                alu_start = 1'b1; opcode = 5'd0; src_sel = 3'd7; imm = 32'd1; y_in = 1'b1;
            end
            tick();
            idleInputs();
            if (i == WIDTH) busyMid = alu_busy;
            if (alu_done) begin
                lat = i;
                break;
            end
        end
        checkOutput("mul latency", lat, WIDTH + 1);
        checkOutput("mul busy at k+WIDTH", {63'd0, busyMid}, 1);
        checkOutput("mul busy clears", {63'd0, alu_busy}, 0);
        readZ(z);
        checkOutput("mul Z", z, 64'hFFFFFFFF_FFFD0000);

        runIter(5'd11, 32'h80000000, 32'hFFFFFFFF, z, lat);
        checkOutput("mul minint Z", z, 64'h00000000_80000000);
        runIter(5'd12, 32'hFFFFFFF9, 32'd2, z, lat);
        checkOutput("div -7/2 latency", lat, WIDTH + 1);
        checkOutput("div -7/2 Z", z, 64'hFFFFFFFF_FFFFFFFD);
        runIter(5'd12, 32'd9, 32'd0, z, lat);
        checkOutput("div 9/0 Z", z, 64'h00000009_FFFFFFFF);
        runIter(5'd12, 32'd7, 32'hFFFFFFFE, z, lat);
        checkOutput("div 7/-2 Z", z, 64'h00000001_FFFFFFFD);
        runIter(5'd12, 32'd100, 32'd7, z, lat);
        checkOutput("div 100/7 Z", z, 64'h00000002_0000000E);
`else
        addVec("mul invalid", 5'd11, 32'd5, 32'd7, 64'd0);
        addVec("div invalid", 5'd12, 32'd9, 32'd3, 64'd0);
        loadY(32'd5);
        startOp(5'd11, 32'd7);
        checkOutput("mul no busy", {63'd0, alu_busy}, 0);
        checkOutput("mul single done", {63'd0, alu_done}, 1);
`endif

        addVec("add",        5'd0,  32'd5,        32'd7,        64'd12);
        addVec("add wrap",   5'd0,  32'hFFFFFFFF, 32'd2,        64'd1);
        addVec("sub",        5'd1,  32'd3,        32'd5,        64'hFFFFFFFE);
        addVec("and",        5'd2,  32'hF0F0,     32'hFF00,     64'hF000);
        addVec("or",         5'd3,  32'hF0F0,     32'h0F0F,     64'hFFFF);
        addVec("shr",        5'd4,  32'h80000000, 32'd4,        64'h08000000);
        addVec("shra",       5'd5,  32'h80000000, 32'd4,        64'hF8000000);
        addVec("shl 31",     5'd6,  32'd1,        32'd31,       64'h80000000);
        addVec("shl amt 33", 5'd6,  32'd3,        32'd33,       64'd6);
        addVec("ror",        5'd7,  32'd1,        32'd1,        64'h80000000);
        addVec("rol",        5'd8,  32'h80000001, 32'd4,        64'h18);
        addVec("neg",        5'd9,  32'd0,        32'd5,        64'hFFFFFFFB);
        addVec("not",        5'd10, 32'd0,        32'd0,        64'hFFFFFFFF);
        addVec("op 13",      5'd13, 32'd5,        32'd7,        64'd0);
        addVec("op 31",      5'd31, 32'd5,        32'd7,        64'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

`ifdef PARAM_DATAPATH_MULDIV_EN
        // clr at start+10 of a DIV must abort without a Z write or done pulse.
        loadY(32'd100);
        startOp(5'd12, 32'd7);
        for (int i = 1; i <= 9; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("abort busy", {63'd0, alu_busy}, 0);
        checkOutput("abort done", {63'd0, alu_done}, 0);
        readZ(z);
        checkOutput("abort Z", z, 0);
        doneSeen = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (alu_done) doneSeen++;
        end
        checkOutput("abort no done later", doneSeen, 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
